// File: rtl/param_alu_core.sv
// param_alu_core
// WIDTH-parametrised ALU datapath driven directly by the funct code.
// Single-cycle logic/arithmetic/shift/move ops produce a registered result
// with a one-cycle out_valid pulse. MULTU and DIVU iterate one bit per cycle
// for WIDTH cycles and write the HI/LO pair on completion.
// WIDTH must be >= 4 and a power of two.

module param_alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] Output,
  output logic             out_valid,
  output logic             div_zero,
  output logic             bad_op
);

  // Shift-amount width, derived from WIDTH.
  localparam int SHW = $clog2(WIDTH);

  // Funct codes understood by the core.
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Architectural HI/LO pair, written only when a MULTU/DIVU finishes.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Shared iteration registers.
  //   MUL: opnd = multiplicand, work_hi = partial sum, work_lo = multiplier
  //        (consumed from bit 0 while product bits shift in from the top).
  //   DIV: opnd = divisor, work_hi = partial remainder, work_lo = dividend
  //        (shifted out from the top while quotient bits shift in at bit 0).
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [SHW-1:0]   cnt;
  logic             last;

  // Request decode.
  logic             accept;
  logic             mul_start;
  logic             div_start;
  logic             div0_start;
  logic             op_single;
  logic             op_bad;
  logic [WIDTH-1:0] op_res;

  // One-step results for each iterative operation.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi_nxt;
  logic [WIDTH-1:0] div_lo_nxt;

  assign in_ready   = (state == IDLE) && reset;
  assign accept     = in_valid && in_ready;
  assign mul_start  = accept && (Signal == FN_MULTU);
  assign div_start  = accept && (Signal == FN_DIVU) && (dataB != '0);
  assign div0_start = accept && (Signal == FN_DIVU) && (dataB == '0);
  assign last       = (cnt == SHW'(WIDTH - 1));

  // Decode single-cycle operations and compute their result.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    op_res    = '0;
    op_single = 1'b0;
    op_bad    = 1'b0;
    case (Signal)
      FN_AND: begin
        op_res    = dataA & dataB;
        op_single = 1'b1;
      end
      FN_OR: begin
        op_res    = dataA | dataB;
        op_single = 1'b1;
      end
      FN_ADD: begin
        op_res    = dataA + dataB;
        op_single = 1'b1;
      end
      FN_SUB: begin
        op_res    = dataA - dataB;
        op_single = 1'b1;
      end
      FN_SLT: begin
        op_res    = WIDTH'($signed(dataA) < $signed(dataB));
        op_single = 1'b1;
      end
      FN_SRL: begin
        op_res    = dataA >> dataB[SHW-1:0];
        op_single = 1'b1;
      end
      FN_SLL: begin
        op_res    = dataA << dataB[SHW-1:0];
        op_single = 1'b1;
      end
      FN_MFHI: begin
        op_res    = hi;
        op_single = 1'b1;
      end
      FN_MFLO: begin
        op_res    = lo;
        op_single = 1'b1;
      end
      FN_MULTU, FN_DIVU: begin
        op_single = 1'b0;
      end
      default: begin
        op_res    = '0;
        op_single = 1'b1;
        op_bad    = 1'b1;
      end
    endcase
  end

  // One shift-add multiply step and one restoring-divide step.
  always_comb begin
    mul_sum    = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : '0)};
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], work_lo[WIDTH-1:1]};

    // The remainder is always below the divisor, so the shifted value fits
    // in WIDTH+1 bits and the difference, when taken, fits in WIDTH bits.
    div_shift  = {work_hi, work_lo[WIDTH-1]};
    div_ge     = div_shift >= {1'b0, opnd};
    div_diff   = div_shift[WIDTH-1:0] - opnd;
    div_hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_lo_nxt = {work_lo[WIDTH-2:0], div_ge};
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start an iteration on MULTU/DIVU, return after WIDTH steps.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mul_start) begin
          next_state = MUL;
        end else if (div_start) begin
          next_state = DIV;
        end
      end
      MUL, DIV: begin
        if (last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: result register, HI/LO, iteration registers and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi        <= '0;
      lo        <= '0;
      Output    <= '0;
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      bad_op    <= 1'b0;
      opnd      <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      bad_op    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (op_single) begin
              Output    <= op_res;
              out_valid <= 1'b1;
              bad_op    <= op_bad;
            end else if (mul_start) begin
              opnd    <= dataA;
              work_hi <= '0;
              work_lo <= dataB;
            end else if (div_start) begin
              div_zero <= 1'b0;
              opnd     <= dataB;
              work_hi  <= '0;
              work_lo  <= dataA;
            end else if (div0_start) begin
              // Divide by zero finishes immediately with a saturated quotient.
              hi        <= dataA;
              lo        <= '1;
              Output    <= '1;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          work_hi <= mul_hi_nxt;
          work_lo <= mul_lo_nxt;
          cnt     <= cnt + 1'b1;
          if (last) begin
            hi        <= mul_hi_nxt;
            lo        <= mul_lo_nxt;
            Output    <= mul_lo_nxt;
            out_valid <= 1'b1;
          end
        end
        DIV: begin
          work_hi <= div_hi_nxt;
          work_lo <= div_lo_nxt;
          cnt     <= cnt + 1'b1;
          if (last) begin
            hi        <= div_hi_nxt;
            lo        <= div_lo_nxt;
            Output    <= div_lo_nxt;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu_core.sv
// Directed bench for param_alu_core: a WIDTH=32 instance for the main
// function and a WIDTH=8 instance for the narrow multiply and bad-op cases.

module tb_param_alu_core;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_BAD   = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        v32;
  logic        rdy32;
  logic [5:0]  s32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [31:0] o32;
  logic        ov32;
  logic        dz32;
  logic        bo32;

  logic        v8;
  logic        rdy8;
  logic [5:0]  s8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [7:0]  o8;
  logic        ov8;
  logic        dz8;
  logic        bo8;

  int n_checks = 0;
  int n_fail   = 0;

  param_alu_core #(.WIDTH(32)) dut32 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (v32),
    .in_ready (rdy32),
    .Signal   (s32),
    .dataA    (a32),
    .dataB    (b32),
    .Output   (o32),
    .out_valid(ov32),
    .div_zero (dz32),
    .bad_op   (bo32)
  );

  param_alu_core #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (v8),
    .in_ready (rdy8),
    .Signal   (s8),
    .dataA    (a8),
    .dataB    (b8),
    .Output   (o8),
    .out_valid(ov8),
    .div_zero (dz8),
    .bad_op   (bo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op on the 32-bit core: result and pulse one cycle after accept.
  task automatic op32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
    v32 = 1'b1;
    s32 = f;
    a32 = a;
    b32 = b;
    check({tag, " ready"}, 64'(rdy32), 64'd1);
    tick();
    v32 = 1'b0;
    check({tag, " valid"}, 64'(ov32), 64'd1);
    check(tag, 64'(o32), 64'(exp));
  endtask

  // Iterative op on the 32-bit core: checks div_zero right after accept,
  // latency to out_valid, that in_ready stays low while busy, and the result.
  task automatic long32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic hold, input logic exp_dz, input logic [31:0] exp,
                        input string tag);
    int lat;
    int rdy_seen;
    v32 = 1'b1;
    s32 = f;
    a32 = a;
    b32 = b;
    tick();
    if (!hold) v32 = 1'b0;
    check({tag, " div_zero"}, 64'(dz32), 64'(exp_dz));
    lat = 1;
    rdy_seen = 0;
    while (ov32 !== 1'b1 && lat < 40) begin
      if (rdy32) rdy_seen++;
      tick();
      lat++;
    end
    v32 = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy ready"}, 64'(rdy_seen), 64'd0);
    check({tag, " ready back"}, 64'(rdy32), 64'd1);
    check(tag, 64'(o32), 64'(exp));
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat8;
    int ov_cnt;

    reset = 1'b0;
    v32 = 1'b0; s32 = '0; a32 = '0; b32 = '0;
    v8  = 1'b0; s8  = '0; a8  = '0; b8  = '0;
    tick();
    tick();

    // Reset state.
    check("rst Output", 64'(o32), 64'd0);
    check("rst out_valid", 64'(ov32), 64'd0);
    check("rst div_zero", 64'(dz32), 64'd0);
    check("rst bad_op", 64'(bo32), 64'd0);
    check("rst ready low", 64'(rdy32), 64'd0);
    check("rst Output w8", 64'(o8), 64'd0);
    check("rst div_zero w8", 64'(dz8), 64'd0);

    reset = 1'b1;
    tick();
    check("ready after reset", 64'(rdy32), 64'd1);

    // Back-to-back single-cycle ops.
    op32(F_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "add wrap");
    op32(F_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub wrap");
    op32(F_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt neg<pos");
    op32(F_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, "slt pos<neg");
    op32(F_SRL, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, "srl shamt1");
    op32(F_SLL, 32'd1, 32'd31, 32'h8000_0000, "sll 31");
    op32(F_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, "and");
    op32(F_OR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, "or");
    tick();
    check("idle no valid", 64'(ov32), 64'd0);
    check("Output holds", 64'(o32), 64'h0000_FFF0);

    // MULTU with in_valid held through the busy period.
    long32(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, "multu");
    op32(F_MFHI, 32'd0, 32'd0, 32'hFFFF_FFFE, "mfhi multu");
    op32(F_MFLO, 32'd0, 32'd0, 32'h0000_0001, "mflo multu");

    // DIVU and divide-by-zero stickiness.
    long32(F_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, "divu 100/7");
    op32(F_MFHI, 32'd0, 32'd0, 32'd2, "mfhi 100/7");
    check("div_zero clear", 64'(dz32), 64'd0);

    v32 = 1'b1; s32 = F_DIVU; a32 = 32'd9; b32 = 32'd0;
    tick();
    v32 = 1'b0;
    check("div0 valid", 64'(ov32), 64'd1);
    check("div0 div_zero", 64'(dz32), 64'd1);
    op32(F_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFF, "mflo div0");
    op32(F_MFHI, 32'd0, 32'd0, 32'd9, "mfhi div0");
    check("div_zero sticky", 64'(dz32), 64'd1);

    long32(F_DIVU, 32'd8, 32'd2, 1'b0, 1'b0, 32'd4, "divu 8/2");
    op32(F_MFHI, 32'd0, 32'd0, 32'd0, "mfhi 8/2");

    op32(F_BAD, 32'h1234_5678, 32'h1, 32'd0, "bad op w32");
    check("bad_op pulse w32", 64'(bo32), 64'd1);

    // Reset in the middle of a DIVU aborts it without a result.
    op32(F_MFLO, 32'd0, 32'd0, 32'd4, "mflo before abort");
    v32 = 1'b1; s32 = F_DIVU; a32 = 32'd1000; b32 = 32'd3;
    tick();
    v32 = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    check("abort valid", 64'(ov32), 64'd0);
    check("abort Output", 64'(o32), 64'd0);
    check("abort ready low", 64'(rdy32), 64'd0);
    reset = 1'b1;
    tick();
    check("abort ready back", 64'(rdy32), 64'd1);
    ov_cnt = 0;
    repeat (40) begin
      if (ov32) ov_cnt++;
      tick();
    end
    check("abort no pulse", 64'(ov_cnt), 64'd0);
    op32(F_MFLO, 32'd0, 32'd0, 32'd0, "mflo after abort");
    op32(F_MFHI, 32'd0, 32'd0, 32'd0, "mfhi after abort");

    // WIDTH=8 instance: narrow multiply and unlisted code.
    v8 = 1'b1; s8 = F_MULTU; a8 = 8'hFF; b8 = 8'h02;
    tick();
    v8 = 1'b0;
    lat8 = 1;
    while (ov8 !== 1'b1 && lat8 < 20) begin
      tick();
      lat8++;
    end
    check("w8 multu latency", 64'(lat8), 64'd9);
    check("w8 multu LO", 64'(o8), 64'hFE);
    v8 = 1'b1; s8 = F_MFHI;
    tick();
    v8 = 1'b0;
    check("w8 mfhi", 64'(o8), 64'h01);
    v8 = 1'b1; s8 = F_BAD; a8 = 8'h55; b8 = 8'h33;
    tick();
    v8 = 1'b0;
    check("w8 bad Output", 64'(o8), 64'h00);
    check("w8 bad_op", 64'(bo8), 64'd1);
    check("w8 bad valid", 64'(ov8), 64'd1);
    tick();
    check("w8 bad_op falls", 64'(bo8), 64'd0);
    check("w8 valid falls", 64'(ov8), 64'd0);
    v8 = 1'b1; s8 = F_MFLO;
    tick();
    v8 = 1'b0;
    check("w8 mflo unchanged", 64'(o8), 64'hFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_alu_core.md
Name: param_alu_core

Overview:
- Next-generation ALU datapath, parametrised in WIDTH: single-cycle logic/arith/shift ops plus iterative unsigned multiply and divide writing HI/LO, with a valid/ready handshake on input and a registered result with valid pulse.
- Sits between the decode/issue stage and writeback; the funct code drives it directly, with no separate control block.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operation request.
- in_ready  output  1  high when the core accepts a request this cycle.
- Signal  input  6  funct code: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, SLL=0, MULTU=25, DIVU=27, MFHI=16, MFLO=18.
- dataA  input  WIDTH  operand A.
- dataB  input  WIDTH  operand B.
- Output  output  WIDTH  registered result.
- out_valid  output  1  one-cycle pulse: Output holds a new result.
- div_zero  output  1  sticky; set by DIVU with dataB==0, cleared by the next accepted DIVU with dataB!=0.
- bad_op  output  1  one-cycle pulse with out_valid when Signal is an unlisted code.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; HI=LO=0; Output=0; out_valid=0; div_zero=0; bad_op=0. This aborts any in-flight MULTU/DIVU with no out_valid.
- Accept occurs when in_valid && in_ready. in_ready = (state==IDLE) && reset==1. Requests made while busy are ignored; the requester must hold them.
- FSM states: IDLE, MUL, DIV.
  - IDLE: on accept of MULTU -> MUL; on accept of DIVU -> DIV; on any other accept, stay in IDLE.
  - MUL and DIV each run a count of WIDTH iterations, 1 bit per cycle, then return to IDLE.
- Single-cycle ops: Output and out_valid are registered at the accept edge, so out_valid is high the cycle after accept. Back-to-back accepts give an out_valid every cycle.
- Arithmetic rules:
  - ADD/SUB: modulo 2^WIDTH, no overflow trap.
  - SLT: signed compare; Output = 1 if $signed(dataA) < $signed(dataB), else 0.
  - SRL: Output = dataA >> dataB[SHW-1:0], logical. SLL: Output = dataA << dataB[SHW-1:0]. Upper bits of dataB are ignored.
  - MFHI/MFLO: Output = HI/LO as of the accept cycle.
  - Unlisted code: Output = 0, bad_op pulses, HI/LO unchanged.
- MULTU: shift-add over a 2*WIDTH-bit product, with operands latched at accept.
  - After WIDTH iteration cycles: {HI,LO} = dataA*dataB (unsigned), Output = LO, out_valid pulses.
  - out_valid is high at cycle accept+WIDTH+1, and in_ready returns on that same cycle.
- DIVU: restoring divide, unsigned, operands latched at accept. Completes as MULTU: LO = quotient, HI = remainder, Output = LO, pulse at accept+WIDTH+1.
- DIVU with dataB==0: no iteration. Next cycle: LO = all ones, HI = dataA, div_zero=1, out_valid pulses, state stays IDLE.
- HI/LO change only on MULTU/DIVU completion. An MFHI/MFLO accepted the cycle after completion sees the new values.
- out_valid is never asserted without a preceding accept. Output holds its value between pulses.

Test Plan:
- WIDTH=32: ADD 0xFFFFFFFF+2 -> Output=0x00000001, out_valid 1 cycle after accept. SUB 5-7 -> 0xFFFFFFFE. SLT A=0xFFFFFFFF, B=1 -> 1.
- SRL A=0x80000000, B=0x00000021 (shamt 1) -> 0x40000000. SLL A=1, B=31 -> 0x80000000. AND/OR 0xF0F0, 0x0FF0 -> 0x00F0/0xFFF0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> out_valid at accept+33, Output=LO=0x00000001. Then MFHI -> 0xFFFFFFFE, MFLO -> 0x00000001. in_ready=0 for cycles accept+1..accept+32.
- DIVU 100/7 -> LO=14, HI=2, div_zero=0. Then DIVU 9/0 -> next cycle LO=0xFFFFFFFF, HI=9, div_zero=1. Then DIVU 8/2 -> div_zero clears at accept.
- Start DIVU, assert reset low at iteration 10 -> no out_valid, HI=LO=0, in_ready high the cycle after reset releases. Held in_valid during busy -> exactly one accept.
- WIDTH=8 instance: MULTU 0xFF*0x02 -> HI=0x01, LO=0xFE at accept+9. Signal=6'b111111 -> Output=0, bad_op pulse.
